// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and the SRAM-like
// data port. The controller (master) drives the request side. The memory
// (slave) answers with addr_ok, then later with data_ok and the read word.
interface mem_access_ctrl_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store access controller.
// It issues one bus transaction per aligned load/store and flags misaligned
// addresses without touching the bus. The pipeline is stalled while a
// transaction is in flight. The read word is registered together with the
// size, byte offset and sign that the load-extension stage needs.
// A flush that arrives after a request has been issued never withdraws it.
// Instead the transaction is carried to completion and its result is dropped.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    input  logic        pipe_hold,
    mem_access_ctrl_if.master data,
    output logic        mem_stall,
    output logic        ld_valid,
    output logic [31:0] ld_rdata,
    output logic [1:0]  ld_size,
    output logic [1:0]  ld_offset,
    output logic        ld_sign,
    output logic        adel,
    output logic        ades
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_reg, state_next;
    logic        discard_reg, discard_next;
    logic        wr_reg;
    logic [1:0]  size_reg;
    logic        sign_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;

    logic        misalign;
    logic        start;
    logic [31:0] wdata_rep;

    // Byte lanes of the replicated store data. A byte store copies byte 0
    // into every lane. A half store copies half 0 into both halves.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_rep[gi*8 +: 8] =
                (mem_size == 2'b00) ? mem_wdata[7:0] :
                (mem_size == 2'b01) ? mem_wdata[(gi%2)*8 +: 8] :
                                      mem_wdata[gi*8 +: 8];
        end
    endgenerate

    // State and discard-flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            discard_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            discard_reg <= discard_next;
        end
    end

    // Next-state logic, alignment check, stall and exception outputs.
    always_comb begin
        state_next   = state_reg;
        discard_next = discard_reg;
        misalign     = 1'b0;
        start        = 1'b0;
        adel         = 1'b0;
        ades         = 1'b0;
        mem_stall    = 1'b0;
        ld_valid     = 1'b0;

        case (mem_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = mem_addr[0];
            default: misalign = (mem_addr[1:0] != 2'b00);
        endcase

        case (state_reg)
            IDLE: begin
                adel  = mem_en & ~mem_wr & misalign;
                ades  = mem_en &  mem_wr & misalign;
                start = mem_en & ~misalign & ~flush;
                if (start) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (data.addr_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (data.data_ok) begin
                    state_next = (discard_reg | flush) ? IDLE : DONE;
                end
            end
            DONE: begin
                ld_valid = ~wr_reg;
                if (~pipe_hold | flush) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if ((state_reg == REQ || state_reg == WAIT) && flush) begin
            discard_next = 1'b1;
        end
        if (state_next == IDLE) begin
            discard_next = 1'b0;
        end

        mem_stall = start | (state_reg == REQ) | (state_reg == WAIT);
    end

    // Operation fields are captured on start, and the read word is captured on data_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_reg    <= 1'b0;
            size_reg  <= 2'b00;
            sign_reg  <= 1'b0;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            rdata_reg <= 32'h0;
        end else begin
            if (start) begin
                wr_reg    <= mem_wr;
                size_reg  <= mem_size;
                sign_reg  <= mem_sign;
                addr_reg  <= mem_addr;
                wdata_reg <= wdata_rep;
            end
            if (state_reg == WAIT && data.data_ok) begin
                rdata_reg <= data.rdata;
            end
        end
    end

    assign data.req   = (state_reg == REQ);
    assign data.wr    = wr_reg;
    assign data.size  = size_reg;
    assign data.addr  = addr_reg;
    assign data.wdata = wdata_reg;

    assign ld_rdata  = rdata_reg;
    assign ld_size   = size_reg;
    assign ld_offset = addr_reg[1:0];
    assign ld_sign   = sign_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. A table of single transactions with
// immediate handshakes is followed by hand-written multi-cycle sequences.
// These cover delayed handshakes, flush placement and reset in mid-flight.
module tb_mem_access_ctrl;

    logic        clk;
    logic        resetn;
    logic        mem_en, mem_wr, mem_sign, flush, pipe_hold;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_stall, ld_valid, ld_sign, adel, ades;
    logic [31:0] ld_rdata;
    logic [1:0]  ld_size, ld_offset;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_size  (mem_size),
        .mem_sign  (mem_sign),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .flush     (flush),
        .pipe_hold (pipe_hold),
        .data      (bus),
        .mem_stall (mem_stall),
        .ld_valid  (ld_valid),
        .ld_rdata  (ld_rdata),
        .ld_size   (ld_size),
        .ld_offset (ld_offset),
        .ld_sign   (ld_sign),
        .adel      (adel),
        .ades      (ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        logic        mis;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    // Each cycle starts 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled mid-cycle.
    task automatic smp();
        #3;
    endtask

    task automatic set_op(input logic en, input logic wr, input logic [1:0] size,
                          input logic sign, input logic [31:0] addr, input logic [31:0] wdata);
        mem_en    = en;
        mem_wr    = wr;
        mem_size  = size;
        mem_sign  = sign;
        mem_addr  = addr;
        mem_wdata = wdata;
    endtask

    // One transaction. addr_ok arrives in the first REQ cycle and data_ok in the first WAIT cycle.
    task automatic run_op(input vec_t v, input int idx);
        cyc();
        set_op(1'b1, v.wr, v.size, v.sign, v.addr, v.wdata);
        smp();
        $display("vec %0d: wr=%0b size=%0b addr=0x%08h mis=%0b", idx, v.wr, v.size, v.addr, v.mis);
        chk($sformatf("v%0d adel", idx), {31'b0, adel}, {31'b0, ~v.wr & v.mis});
        chk($sformatf("v%0d ades", idx), {31'b0, ades}, {31'b0, v.wr & v.mis});
        chk($sformatf("v%0d stall0", idx), {31'b0, mem_stall}, {31'b0, ~v.mis});
        if (v.mis) begin
            cyc();
            mem_en = 1'b0;
            smp();
            chk($sformatf("v%0d no_req", idx), {31'b0, bus.req}, 32'd0);
            chk($sformatf("v%0d no_stall", idx), {31'b0, mem_stall}, 32'd0);
        end else begin
            cyc();
            mem_en = 1'b0;
            bus.addr_ok = 1'b1;
            smp();
            chk($sformatf("v%0d req", idx), {31'b0, bus.req}, 32'd1);
            chk($sformatf("v%0d bus_wr", idx), {31'b0, bus.wr}, {31'b0, v.wr});
            chk($sformatf("v%0d bus_size", idx), {30'b0, bus.size}, {30'b0, v.size});
            chk($sformatf("v%0d bus_addr", idx), bus.addr, v.addr);
            chk($sformatf("v%0d bus_wdata", idx), bus.wdata, v.exp_wdata);
            chk($sformatf("v%0d stall1", idx), {31'b0, mem_stall}, 32'd1);
            cyc();
            bus.addr_ok = 1'b0;
            bus.data_ok = 1'b1;
            bus.rdata   = v.rdata;
            smp();
            chk($sformatf("v%0d req_wait", idx), {31'b0, bus.req}, 32'd0);
            chk($sformatf("v%0d stall2", idx), {31'b0, mem_stall}, 32'd1);
            cyc();
            bus.data_ok = 1'b0;
            bus.rdata   = 32'h0;
            smp();
            chk($sformatf("v%0d ld_valid", idx), {31'b0, ld_valid}, {31'b0, ~v.wr});
            if (!v.wr) chk($sformatf("v%0d ld_rdata", idx), ld_rdata, v.rdata);
            chk($sformatf("v%0d ld_size", idx), {30'b0, ld_size}, {30'b0, v.size});
            chk($sformatf("v%0d ld_offset", idx), {30'b0, ld_offset}, {30'b0, v.addr[1:0]});
            chk($sformatf("v%0d ld_sign", idx), {31'b0, ld_sign}, {31'b0, v.sign});
            chk($sformatf("v%0d stall3", idx), {31'b0, mem_stall}, 32'd0);
            cyc();
            smp();
            chk($sformatf("v%0d idle_valid", idx), {31'b0, ld_valid}, 32'd0);
            chk($sformatf("v%0d idle_stall", idx), {31'b0, mem_stall}, 32'd0);
        end
    endtask

    // Drive a load into REQ, accept it immediately, and leave the controller at the start of WAIT.
    task automatic lw_to_wait(input logic [31:0] addr);
        cyc();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, addr, 32'h0);
        cyc();
        mem_en = 1'b0;
        bus.addr_ok = 1'b1;
        cyc();
        bus.addr_ok = 1'b0;
    endtask

    initial begin
        vec_t lbu, lw2;

        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF, 32'h0,          1'b0};
        vecs[1]  = '{1'b1, 2'b00, 1'b0, 32'h0000_2003, 32'h0000_00A5, 32'h0,          32'hA5A5_A5A5, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'h0000_1001, 32'h0,          32'h0,          32'h0,          1'b1};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 32'h0000_1002, 32'h1111_2222, 32'h0,          32'h0,          1'b1};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_BEEF, 32'h0,          32'hBEEF_BEEF, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h0000_4001, 32'h0,          32'h1122_3344, 32'h0,          1'b0};
        vecs[6]  = '{1'b0, 2'b11, 1'b0, 32'h0000_5004, 32'h0,          32'h5555_AAAA, 32'h0,          1'b0};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 32'h0000_5006, 32'h0,          32'h0,          32'h0,          1'b1};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_6000, 32'hCAFE_F00D, 32'h0,          32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_7001, 32'h0000_1234, 32'h0,          32'h0,          1'b1};
        vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h0000_7002, 32'h0,          32'h8000_7FFF, 32'h0,          1'b0};

        resetn = 1'b0;
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        flush = 1'b0;
        pipe_hold = 1'b0;
        bus.addr_ok = 1'b0;
        bus.data_ok = 1'b0;
        bus.rdata   = 32'h0;

        // Reset state
        cyc();
        cyc();
        smp();
        $display("reset state");
        chk("rst req", {31'b0, bus.req}, 32'd0);
        chk("rst addr", bus.addr, 32'd0);
        chk("rst stall", {31'b0, mem_stall}, 32'd0);
        chk("rst ld_valid", {31'b0, ld_valid}, 32'd0);
        chk("rst ld_rdata", ld_rdata, 32'd0);
        #2;
        resetn = 1'b1;

        // Table of single transactions
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], i);
        end

        // An aligned op in IDLE together with flush does not start
        cyc();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_A000, 32'h0);
        flush = 1'b1;
        smp();
        $display("seq flush_at_start");
        chk("fs stall", {31'b0, mem_stall}, 32'd0);
        cyc();
        mem_en = 1'b0;
        flush = 1'b0;
        smp();
        chk("fs no_req", {31'b0, bus.req}, 32'd0);

        // Delayed handshakes and pipe_hold in DONE
        $display("seq delayed handshakes");
        cyc();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0);
        smp();
        chk("dl stall0", {31'b0, mem_stall}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            mem_en = 1'b0;
            bus.addr_ok = (c == 4);
            smp();
            chk($sformatf("dl req c%0d", c), {31'b0, bus.req}, 32'd1);
            chk($sformatf("dl stall c%0d", c), {31'b0, mem_stall}, 32'd1);
        end
        for (int c = 5; c <= 6; c++) begin
            cyc();
            bus.addr_ok = 1'b0;
            bus.data_ok = (c == 6);
            bus.rdata   = 32'h0BAD_F00D;
            smp();
            chk($sformatf("dl req c%0d", c), {31'b0, bus.req}, 32'd0);
            chk($sformatf("dl stall c%0d", c), {31'b0, mem_stall}, 32'd1);
            chk($sformatf("dl valid c%0d", c), {31'b0, ld_valid}, 32'd0);
        end
        for (int c = 7; c <= 9; c++) begin
            cyc();
            bus.data_ok = 1'b0;
            pipe_hold = (c != 9);
            smp();
            chk($sformatf("dl valid c%0d", c), {31'b0, ld_valid}, 32'd1);
            chk($sformatf("dl stall c%0d", c), {31'b0, mem_stall}, 32'd0);
        end
        chk("dl rdata", ld_rdata, 32'h0BAD_F00D);
        cyc();
        smp();
        chk("dl released", {31'b0, ld_valid}, 32'd0);

        // Flush in WAIT, with data_ok two cycles later
        $display("seq flush in WAIT");
        lw_to_wait(32'h0000_1020);
        flush = 1'b1;
        smp();
        chk("fw stall", {31'b0, mem_stall}, 32'd1);
        cyc();
        flush = 1'b0;
        smp();
        chk("fw stall2", {31'b0, mem_stall}, 32'd1);
        cyc();
        bus.data_ok = 1'b1;
        bus.rdata   = 32'h7777_7777;
        smp();
        chk("fw valid", {31'b0, ld_valid}, 32'd0);
        cyc();
        bus.data_ok = 1'b0;
        smp();
        chk("fw idle valid", {31'b0, ld_valid}, 32'd0);
        chk("fw idle stall", {31'b0, mem_stall}, 32'd0);
        lbu = '{1'b0, 2'b00, 1'b0, 32'h0000_3002, 32'h0, 32'h00AB_0000, 32'h0, 1'b0};
        run_op(lbu, 100);

        // Flush in REQ. The request stays up until addr_ok, and the result is dropped.
        $display("seq flush in REQ");
        cyc();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1030, 32'h0);
        cyc();
        mem_en = 1'b0;
        flush = 1'b1;
        smp();
        chk("fr req1", {31'b0, bus.req}, 32'd1);
        cyc();
        flush = 1'b0;
        smp();
        chk("fr req held", {31'b0, bus.req}, 32'd1);
        bus.addr_ok = 1'b1;
        cyc();
        bus.addr_ok = 1'b0;
        bus.data_ok = 1'b1;
        smp();
        chk("fr wait stall", {31'b0, mem_stall}, 32'd1);
        cyc();
        bus.data_ok = 1'b0;
        smp();
        chk("fr no valid", {31'b0, ld_valid}, 32'd0);
        chk("fr idle stall", {31'b0, mem_stall}, 32'd0);

        // Flush together with data_ok
        $display("seq flush with data_ok");
        lw_to_wait(32'h0000_1040);
        flush = 1'b1;
        bus.data_ok = 1'b1;
        cyc();
        flush = 1'b0;
        bus.data_ok = 1'b0;
        smp();
        chk("fd no valid", {31'b0, ld_valid}, 32'd0);
        chk("fd stall", {31'b0, mem_stall}, 32'd0);

        // Flush in DONE with pipe_hold high
        $display("seq flush in DONE");
        lw_to_wait(32'h0000_1050);
        bus.data_ok = 1'b1;
        bus.rdata   = 32'h2468_ACE0;
        cyc();
        bus.data_ok = 1'b0;
        pipe_hold = 1'b1;
        flush = 1'b1;
        smp();
        chk("fdn valid", {31'b0, ld_valid}, 32'd1);
        cyc();
        flush = 1'b0;
        smp();
        chk("fdn released", {31'b0, ld_valid}, 32'd0);
        chk("fdn stall", {31'b0, mem_stall}, 32'd0);
        pipe_hold = 1'b0;

        // Reset in WAIT, then a stray data_ok
        $display("seq reset in WAIT");
        lw_to_wait(32'h0000_8003 & 32'hFFFF_FFFC);
        smp();
        #2;
        resetn = 1'b0;
        #1;
        chk("rw req", {31'b0, bus.req}, 32'd0);
        chk("rw wr", {31'b0, bus.wr}, 32'd0);
        chk("rw size", {30'b0, bus.size}, 32'd0);
        chk("rw addr", bus.addr, 32'd0);
        chk("rw wdata", bus.wdata, 32'd0);
        chk("rw stall", {31'b0, mem_stall}, 32'd0);
        chk("rw ld_size", {30'b0, ld_size}, 32'd0);
        chk("rw ld_valid", {31'b0, ld_valid}, 32'd0);
        cyc();
        resetn = 1'b1;
        cyc();
        bus.data_ok = 1'b1;
        bus.rdata   = 32'h9999_9999;
        smp();
        chk("rw stray stall", {31'b0, mem_stall}, 32'd0);
        cyc();
        bus.data_ok = 1'b0;
        smp();
        chk("rw stray valid", {31'b0, ld_valid}, 32'd0);
        chk("rw stray rdata", ld_rdata, 32'd0);
        lw2 = '{1'b0, 2'b10, 1'b0, 32'h0000_9000, 32'h0, 32'h1357_9BDF, 32'h0, 1'b0};
        run_op(lw2, 101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
